// File: rtl/stim_pattern_gen_if.sv
// Control, configuration and sample bus of the stim_pattern_gen test-pattern source.
// The master drives control/config and observes samples; the slave is the generator.
interface stim_pattern_gen_if #(
  parameter int WIDTH    = 18,
  parameter int IDX_W    = 16,
  parameter int FRAMES_W = 8
);
  logic                          sam_clk_ena;
  logic                          start;
  logic                          stop;
  logic [2:0]                    mode;
  logic [IDX_W-1:0]              period;
  logic [IDX_W-1:0]              offset;
  logic signed [WIDTH-1:0]       amplitude;
  logic [FRAMES_W-1:0]           num_frames;
  logic signed [WIDTH-1:0]       x_out;
  logic                          valid;
  logic                          marker;
  logic                          done;
  logic                          running;
  logic signed [WIDTH+IDX_W-1:0] frame_sum;

  modport master (
    output sam_clk_ena, start, stop, mode, period, offset, amplitude, num_frames,
    input  x_out, valid, marker, done, running, frame_sum
  );

  modport slave (
    input  sam_clk_ena, start, stop, mode, period, offset, amplitude, num_frames,
    output x_out, valid, marker, done, running, frame_sum
  );
endinterface

// File: rtl/stim_pattern_gen.sv
// Programmable impulse/step/square/4-ASK PRBS/ramp source, one sample per sam_clk_ena.
// Optional per-frame checksum on frame_sum is enabled by defining STIM_PATTERN_GEN_CHECKSUM_EN.
module stim_pattern_gen #(
  parameter int          WIDTH     = 18,
  parameter int          IDX_W     = 16,
  parameter int          FRAMES_W  = 8,
  parameter logic [21:0] LFSR_SEED = 22'h3FFFFF
) (
  input logic            sys_clk,
  input logic            reset,
  stim_pattern_gen_if.slave bus
);
  localparam logic [21:0]             SEED    = (LFSR_SEED == 22'd0) ? 22'd1 : LFSR_SEED;
  localparam logic signed [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [IDX_W-1:0]        IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [FRAMES_W-1:0]     FR_ONE  = {{(FRAMES_W-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              mode_q, mode_d;
  logic [IDX_W-1:0]        period_q, period_d;
  logic [IDX_W-1:0]        offset_q, offset_d;
  logic signed [WIDTH-1:0] amp_q, amp_d;
  logic [FRAMES_W-1:0]     nfr_q, nfr_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [FRAMES_W-1:0]     frame_cnt_q, frame_cnt_d;
  logic [21:0]             lfsr_q, lfsr_d;
  logic signed [WIDTH-1:0] acc_q, acc_d;
  logic signed [WIDTH-1:0] x_out_q, x_out_d;
  logic                    valid_q, valid_d;
  logic                    marker_q, marker_d;
  logic                    done_q, done_d;

  logic signed [WIDTH-1:0] neg_amp, d1, d3, ramp_val, sample;
  logic [FRAMES_W-1:0]     cnt_inc;
  logic                    restart, advance, frame_end, last_frame;

  // stop wins over start; the cycle carrying done is spent leaving RUN, so enables there are dropped
  assign restart    = !bus.stop && bus.start;
  assign advance    = !bus.stop && !bus.start && (state_q == RUN) && !done_q && bus.sam_clk_ena;
  assign frame_end  = (period_q <= IDX_ONE) || (idx_q == period_q - IDX_ONE);
  assign cnt_inc    = frame_cnt_q + FR_ONE;
  assign last_frame = frame_end && (nfr_q != '0) && (cnt_inc == nfr_q);

  // |d| <= 2^(WIDTH-3), so 3d always fits in WIDTH bits
  assign neg_amp = (amp_q == MIN_NEG) ? MAX_POS : -amp_q;
  assign d1      = amp_q >>> 2;
  assign d3      = d1 + (d1 <<< 1);

  always_comb begin
    ramp_val = (idx_q == '0) ? '0 : acc_q + amp_q;
    sample   = '0;
    case (mode_q)
      3'd1: sample = (idx_q == offset_q) ? amp_q : '0;
      3'd2: sample = (idx_q < offset_q) ? '0 : amp_q;
      3'd3: sample = (idx_q < offset_q) ? amp_q : neg_amp;
      3'd4: begin
        case (lfsr_q[1:0])
          2'b00:   sample = -d3;
          2'b01:   sample = -d1;
          2'b10:   sample = d1;
          default: sample = d3;
        endcase
      end
      3'd5:    sample = ramp_val;
      default: sample = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    period_d    = period_q;
    offset_d    = offset_q;
    amp_d       = amp_q;
    nfr_d       = nfr_q;
    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;
    lfsr_d      = lfsr_q;
    acc_d       = acc_q;
    x_out_d     = x_out_q;
    valid_d     = 1'b0;
    marker_d    = 1'b0;
    done_d      = 1'b0;
    if (bus.stop) begin
      state_d = IDLE;
      x_out_d = '0;
    end else if (restart) begin
      state_d     = RUN;
      mode_d      = bus.mode;
      period_d    = bus.period;
      offset_d    = bus.offset;
      amp_d       = bus.amplitude;
      nfr_d       = bus.num_frames;
      idx_d       = '0;
      frame_cnt_d = '0;
      lfsr_d      = SEED;
      acc_d       = '0;
    end else if (state_q == RUN && done_q) begin
      state_d = IDLE;
      x_out_d = '0;
    end else if (advance) begin
      x_out_d  = sample;
      valid_d  = 1'b1;
      marker_d = (idx_q == offset_q);
      acc_d    = ramp_val;
      lfsr_d   = {lfsr_q[20:0], lfsr_q[21] ^ lfsr_q[20]};
      if (frame_end) begin
        idx_d       = '0;
        frame_cnt_d = cnt_inc;
        done_d      = last_frame;
      end else begin
        idx_d = idx_q + IDX_ONE;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mode_q      <= '0;
      period_q    <= '0;
      offset_q    <= '0;
      amp_q       <= '0;
      nfr_q       <= '0;
      idx_q       <= '0;
      frame_cnt_q <= '0;
      lfsr_q      <= SEED;
      acc_q       <= '0;
      x_out_q     <= '0;
      valid_q     <= 1'b0;
      marker_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      period_q    <= period_d;
      offset_q    <= offset_d;
      amp_q       <= amp_d;
      nfr_q       <= nfr_d;
      idx_q       <= idx_d;
      frame_cnt_q <= frame_cnt_d;
      lfsr_q      <= lfsr_d;
      acc_q       <= acc_d;
      x_out_q     <= x_out_d;
      valid_q     <= valid_d;
      marker_q    <= marker_d;
      done_q      <= done_d;
    end
  end

  assign bus.x_out   = x_out_q;
  assign bus.valid   = valid_q;
  assign bus.marker  = marker_q;
  assign bus.done    = done_q;
  assign bus.running = (state_q == RUN);

`ifdef STIM_PATTERN_GEN_CHECKSUM_EN
  logic signed [WIDTH+IDX_W-1:0] sum_acc_q, sum_acc_d, frame_sum_q, frame_sum_d, sum_total;

  assign sum_total = sum_acc_q + {{IDX_W{sample[WIDTH-1]}}, sample};

  always_comb begin
    sum_acc_d   = sum_acc_q;
    frame_sum_d = frame_sum_q;
    if (restart) begin
      sum_acc_d = '0;
    end else if (advance) begin
      if (frame_end) begin
        frame_sum_d = sum_total;
        sum_acc_d   = '0;
      end else begin
        sum_acc_d = sum_total;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      sum_acc_q   <= '0;
      frame_sum_q <= '0;
    end else begin
      sum_acc_q   <= sum_acc_d;
      frame_sum_q <= frame_sum_d;
    end
  end

  assign bus.frame_sum = frame_sum_q;
`else
  assign bus.frame_sum = '0;
`endif
endmodule

// File: tb/tb_stim_pattern_gen.sv
// Scoreboard bench for stim_pattern_gen: stimulus pushes expected samples, a monitor pops on valid.
`timescale 1ns/1ps
module tb_stim_pattern_gen;
  localparam int WIDTH    = 18;
  localparam int IDX_W    = 16;
  localparam int FRAMES_W = 8;

  typedef struct packed {
    logic signed [WIDTH-1:0] x;
    logic                    marker;
    logic                    done;
  } exp_t;

  logic sys_clk = 1'b0;
  logic reset   = 1'b1;
  always #5 sys_clk = ~sys_clk;

  stim_pattern_gen_if #(.WIDTH(WIDTH), .IDX_W(IDX_W), .FRAMES_W(FRAMES_W)) bus ();

  stim_pattern_gen #(
    .WIDTH(WIDTH), .IDX_W(IDX_W), .FRAMES_W(FRAMES_W), .LFSR_SEED(22'h3FFFFF)
  ) dut (
    .sys_clk (sys_clk),
    .reset   (reset),
    .bus     (bus)
  );

  exp_t       exp_q[$];
  int         checks = 0;
  int         passes = 0;
  int         done_seen = 0;
  bit         chk_running_next = 1'b0;
  bit         prbs_track = 1'b0;
  int         prbs_bad = 0;
  bit [3:0]   prbs_seen = '0;
  logic [21:0] m_lfsr;

  task automatic check(string name, longint act, longint expv);
    checks++;
    if (act == expv) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, expv);
  endtask

  task automatic push_exp(int x, bit m, bit d);
    exp_t e;
    e.x      = WIDTH'(x);
    e.marker = m;
    e.done   = d;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic cfg_start(int md, int per, int off, int amp, int nfr);
    bus.mode       = 3'(md);
    bus.period     = IDX_W'(per);
    bus.offset     = IDX_W'(off);
    bus.amplitude  = WIDTH'(amp);
    bus.num_frames = FRAMES_W'(nfr);
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
  endtask

  task automatic ena(int gap);
    bus.sam_clk_ena = 1'b1;
    tick();
    bus.sam_clk_ena = 1'b0;
    repeat (gap - 1) tick();
  endtask

  task automatic drain(string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    tick();
    check(name, exp_q.size(), 0);
  endtask

  // hand-computed 4-ASK levels for amplitude 131071 (d = 32767, 3d = 98301)
  function automatic int prbs_level(logic [1:0] s);
    case (s)
      2'b00:   return -98301;
      2'b01:   return -32767;
      2'b10:   return 32767;
      default: return 98301;
    endcase
  endfunction

  task automatic push_prbs(bit m);
    push_exp(prbs_level(m_lfsr[1:0]), m, 1'b0);
    m_lfsr = {m_lfsr[20:0], m_lfsr[21] ^ m_lfsr[20]};
  endtask

  // Monitor: compares every presented sample against the scoreboard head.
  always @(negedge sys_clk) begin
    exp_t e;
    if (chk_running_next) begin
      chk_running_next = 1'b0;
      check("running_after_done", bus.running, 0);
    end
    if (bus.done) done_seen++;
    if (bus.valid) begin
      if (exp_q.size() == 0) begin
        check("valid_with_empty_queue", bus.valid, 0);
      end else begin
        e = exp_q.pop_front();
        check("x_out", bus.x_out, e.x);
        check("marker", bus.marker, e.marker);
        check("done", bus.done, e.done);
        if (e.done && bus.done) chk_running_next = 1'b1;
        if (prbs_track) begin
          case (int'(bus.x_out))
            -98301:  prbs_seen[0] = 1'b1;
            -32767:  prbs_seen[1] = 1'b1;
            32767:   prbs_seen[2] = 1'b1;
            98301:   prbs_seen[3] = 1'b1;
            default: prbs_bad++;
          endcase
        end
      end
    end else if (bus.done) begin
      check("done_without_valid", bus.valid, 1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit, got %0d checks, expected completion", checks);
    $fatal(1, "timeout");
  end

  initial begin
    longint fs_exp;
    bus.sam_clk_ena = 1'b0;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.mode        = '0;
    bus.period      = '0;
    bus.offset      = '0;
    bus.amplitude   = '0;
    bus.num_frames  = '0;

    // reset state
    #12;
    check("rst_x_out", bus.x_out, 0);
    check("rst_valid", bus.valid, 0);
    check("rst_marker", bus.marker, 0);
    check("rst_done", bus.done, 0);
    check("rst_running", bus.running, 0);
    check("rst_frame_sum", bus.frame_sum, 0);
    @(negedge sys_clk);
    reset = 1'b0;
    tick();

    // enable in IDLE is ignored
    repeat (3) ena(1);
    check("idle_running", bus.running, 0);

    // impulse: two frames of 1000, enable every 4th cycle
    cfg_start(1, 1000, 200, 131071, 0);
    check("impulse_running", bus.running, 1);
    for (int k = 0; k < 2000; k++) begin
      push_exp(((k % 1000) == 200) ? 131071 : 0, (k % 1000) == 200, 1'b0);
      ena(4);
    end
    drain("impulse_drain");
    check("impulse_still_running", bus.running, 1);

    // square with saturated negation, back-to-back enables
    cfg_start(3, 8, 4, -131072, 0);
    for (int k = 0; k < 16; k++) begin
      push_exp(((k % 8) < 4) ? -131072 : 131071, (k % 8) == 4, 1'b0);
      ena(1);
    end
    drain("square_drain");
`ifdef STIM_PATTERN_GEN_CHECKSUM_EN
    fs_exp = -4;
`else
    fs_exp = 0;
`endif
    check("square_frame_sum", bus.frame_sum, fs_exp);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check("stop_running", bus.running, 0);
    check("stop_x_out", bus.x_out, 0);

    // offset >= period: step all zero, square all amplitude, no markers
    cfg_start(2, 4, 6, 7, 0);
    for (int k = 0; k < 8; k++) begin
      push_exp(0, 1'b0, 1'b0);
      ena(1);
    end
    drain("step_off_drain");
    cfg_start(3, 4, 6, 7, 0);
    for (int k = 0; k < 8; k++) begin
      push_exp(7, 1'b0, 1'b0);
      ena(2);
    end
    drain("square_off_drain");

    // period 1: every sample is a frame end, three frames then done
    done_seen = 0;
    cfg_start(5, 1, 0, 3, 3);
    for (int k = 0; k < 3; k++) push_exp(0, 1'b1, k == 2);
    repeat (5) ena(2);
    drain("period1_drain");
    check("period1_done_count", done_seen, 1);

    // PRBS 4-ASK over 4096 samples
    cfg_start(4, 16, 0, 131071, 0);
    m_lfsr     = 22'h3FFFFF;
    prbs_track = 1'b1;
    for (int k = 0; k < 4096; k++) begin
      push_prbs((k % 16) == 0);
      ena(1);
      if (k == 0) check("prbs_first_symbol", bus.x_out, 98301);
    end
    drain("prbs_drain");
    prbs_track = 1'b0;
    check("prbs_out_of_set", prbs_bad, 0);
    check("prbs_levels_seen", prbs_seen, 4'hF);

    // frame limit: ramp, 3 frames of 8, extra enables after done
    done_seen = 0;
    cfg_start(5, 8, 0, 10, 3);
    for (int k = 0; k < 24; k++) push_exp((k % 8) * 10, (k % 8) == 0, k == 23);
    repeat (26) ena(2);
    drain("ramp_drain");
    check("ramp_done_count", done_seen, 1);
    check("ramp_idle_running", bus.running, 0);
    check("ramp_idle_x_out", bus.x_out, 0);

    // start and stop together in RUN
    cfg_start(3, 8, 4, 5, 0);
    push_exp(5, 1'b0, 1'b0);
    push_exp(5, 1'b0, 1'b0);
    ena(1);
    ena(1);
    drain("collide_pre_drain");
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("collide_running", bus.running, 0);
    check("collide_x_out", bus.x_out, 0);
    check("collide_valid", bus.valid, 0);
    repeat (3) ena(1);
    check("collide_idle", bus.running, 0);

    // start alone mid-frame at idx 5 restarts idx and reseeds the LFSR
    cfg_start(4, 16, 0, 131071, 0);
    m_lfsr = 22'h3FFFFF;
    for (int k = 0; k < 5; k++) begin
      push_prbs(k == 0);
      ena(1);
    end
    drain("restart_pre_drain");
    cfg_start(4, 16, 0, 131071, 0);
    bus.amplitude = WIDTH'(1);
    bus.mode      = 3'd0;
    m_lfsr        = 22'h3FFFFF;
    for (int k = 0; k < 3; k++) begin
      push_prbs(k == 0);
      ena(1);
    end
    drain("restart_post_drain");

    // async reset mid-run at idx 5 of impulse mode
    cfg_start(1, 10, 4, 100, 0);
    for (int k = 0; k < 5; k++) begin
      push_exp((k == 4) ? 100 : 0, k == 4, 1'b0);
      ena(1);
    end
    drain("reset_pre_drain");
    check("reset_pre_x_out", bus.x_out, 100);
    @(negedge sys_clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_x_out", bus.x_out, 0);
    check("async_rst_running", bus.running, 0);
    check("async_rst_valid", bus.valid, 0);
    check("async_rst_marker", bus.marker, 0);
    tick();
    tick();
    reset = 1'b0;
    repeat (4) ena(1);
    repeat (3) tick();
    check("post_rst_running", bus.running, 0);
    check("post_rst_queue", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
